// File: rtl/pixel_write_arbiter.sv
// Merges two buffered pixel-write streams onto the VGA adapter write port with
// round-robin arbitration, off-screen clipping and a full-screen clear sweep.

module pixel_write_arbiter_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);

endmodule

module pixel_write_arbiter #(
  parameter int unsigned SCREEN_W   = 320,
  parameter int unsigned SCREEN_H   = 240,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  BG_COLOUR  = 4'h0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear_req,
  output logic       clear_busy,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [8:0] a_x,
  input  logic [8:0] a_y,
  input  logic [3:0] a_colour,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [8:0] b_x,
  input  logic [8:0] b_y,
  input  logic [3:0] b_colour,
  output logic       writeEn,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic [3:0] colour,
  output logic [7:0] drop_count
);

  typedef struct packed {
    logic [8:0] px;
    logic [8:0] py;
    logic [3:0] pc;
  } pix_t;

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  localparam logic [8:0] XLIM = 9'(SCREEN_W);
  localparam logic [8:0] YLIM = 9'(SCREEN_H);
  localparam logic [8:0] XMAX = 9'(SCREEN_W - 1);
  localparam logic [8:0] YMAX = 9'(SCREEN_H - 1);

  state_t     state_q, state_d;
  logic       prefer_b_q, prefer_b_d;
  logic       we_q, we_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic [3:0] col_q, col_d;
  logic [7:0] drop_q, drop_d;
  logic [8:0] cx_q, cx_d, cy_q, cy_d;

  logic a_full, a_empty, b_full, b_empty;
  logic a_push, b_push, pop_a, pop_b;
  logic arb_active, sweep_last, clip;
  pix_t a_in, b_in, a_head, b_head, sel;

  // Ready is gated by reset so upstream sees no capacity while held in reset.
  assign a_ready = resetn & ~a_full;
  assign b_ready = resetn & ~b_full;
  assign a_push  = a_valid & a_ready;
  assign b_push  = b_valid & b_ready;
  assign a_in    = '{px: a_x, py: a_y, pc: a_colour};
  assign b_in    = '{px: b_x, py: b_y, pc: b_colour};

  pixel_write_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pix_t))) u_fifo_a (
    .clk(clock), .rst_n(resetn), .push_i(a_push), .data_i(a_in),
    .pop_i(pop_a), .data_o(a_head), .empty_o(a_empty), .full_o(a_full)
  );

  pixel_write_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pix_t))) u_fifo_b (
    .clk(clock), .rst_n(resetn), .push_i(b_push), .data_i(b_in),
    .pop_i(pop_b), .data_o(b_head), .empty_o(b_empty), .full_o(b_full)
  );

  assign sweep_last = (cx_q == XMAX) && (cy_q == YMAX);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_ARB;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:   if (clear_req)  state_d = ST_CLEAR;
      ST_CLEAR: if (sweep_last) state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase
  end

  always_comb begin
    clear_busy = (state_q == ST_CLEAR);
    arb_active = (state_q == ST_ARB) && !clear_req;
  end

  // With both heads present the pointer picks the source not granted last.
  always_comb begin
    pop_a = arb_active && !a_empty && (b_empty || !prefer_b_q);
    pop_b = arb_active && !b_empty && (a_empty ||  prefer_b_q);
    sel   = pop_b ? b_head : a_head;
    clip  = (sel.px >= XLIM) || (sel.py >= YLIM);
  end

  always_comb begin
    prefer_b_d = prefer_b_q;
    we_d       = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    col_d      = col_q;
    drop_d     = drop_q;
    cx_d       = cx_q;
    cy_d       = cy_q;

    if (pop_a) prefer_b_d = 1'b1;
    if (pop_b) prefer_b_d = 1'b0;

    if (state_q == ST_CLEAR) begin
      we_d  = 1'b1;
      x_d   = cx_q;
      y_d   = cy_q;
      col_d = BG_COLOUR;
      if (cx_q == XMAX) begin
        cx_d = '0;
        cy_d = (cy_q == YMAX) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end else begin
      if (clear_req) begin
        cx_d = '0;
        cy_d = '0;
      end
      if (pop_a || pop_b) begin
        if (clip) begin
          if (drop_q != '1) drop_d = drop_q + 1'b1;
        end else begin
          we_d  = 1'b1;
          x_d   = sel.px;
          y_d   = sel.py;
          col_d = sel.pc;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prefer_b_q <= 1'b0;
      we_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      drop_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
    end else begin
      prefer_b_q <= prefer_b_d;
      we_q       <= we_d;
      x_q        <= x_d;
      y_q        <= y_d;
      col_q      <= col_d;
      drop_q     <= drop_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
    end
  end

  assign writeEn    = we_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = col_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter: vector table for single pixels and
// clipping, hand-written sequences for contention, clear sweep and reset.

module tb_pixel_write_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       clear_req;
  logic       clear_busy;
  logic       a_valid, a_ready;
  logic [8:0] a_x, a_y;
  logic [3:0] a_colour;
  logic       b_valid, b_ready;
  logic [8:0] b_x, b_y;
  logic [3:0] b_colour;
  logic       writeEn;
  logic [8:0] x, y;
  logic [3:0] colour;
  logic [7:0] drop_count;

  pixel_write_arbiter #(
    .SCREEN_W(320), .SCREEN_H(240), .FIFO_DEPTH(4), .BG_COLOUR(4'h0)
  ) dut (
    .clock(clock), .resetn(resetn), .clear_req(clear_req), .clear_busy(clear_busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_colour(a_colour),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_colour(b_colour),
    .writeEn(writeEn), .x(x), .y(y), .colour(colour), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0] px;
    logic [8:0] py;
    logic [3:0] pc;
  } pix_t;

  typedef struct {
    logic [8:0] ax, ay;
    logic [3:0] ac;
    logic       ew;
    logic [8:0] ex, ey;
    logic [3:0] ec;
    logic [7:0] ed;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  pix_t got_q[$];
  int   got_k[$];
  pix_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input int k);
    if (writeEn) begin
      got_q.push_back('{px: x, py: y, pc: colour});
      got_k.push_back(k);
    end
  endtask

  task automatic check_seq(input string tag, input int first_k);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_%0d_x", tag, i), got_q[i].px, exp_q[i].px);
      check($sformatf("%s_%0d_y", tag, i), got_q[i].py, exp_q[i].py);
      check($sformatf("%s_%0d_c", tag, i), got_q[i].pc, exp_q[i].pc);
      check($sformatf("%s_%0d_cycle", tag, i), got_k[i], first_k + i);
    end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int   b_sent, bad, sent;
    logic acc, we_seen;

    vecs[0] = '{ax: 200, ay: 150, ac: 4'h7, ew: 1, ex: 200, ey: 150, ec: 4'h7, ed: 0};
    vecs[1] = '{ax: 320, ay: 10,  ac: 4'h3, ew: 0, ex: 200, ey: 150, ec: 4'h7, ed: 1};
    vecs[2] = '{ax: 5,   ay: 240, ac: 4'h2, ew: 0, ex: 200, ey: 150, ec: 4'h7, ed: 2};
    vecs[3] = '{ax: 5,   ay: 5,   ac: 4'h9, ew: 1, ex: 5,   ey: 5,   ec: 4'h9, ed: 2};
    vecs[4] = '{ax: 319, ay: 239, ac: 4'hF, ew: 1, ex: 319, ey: 239, ec: 4'hF, ed: 2};
    vecs[5] = '{ax: 511, ay: 511, ac: 4'h1, ew: 0, ex: 319, ey: 239, ec: 4'hF, ed: 3};

    resetn = 1'b0; clear_req = 1'b0;
    a_valid = 1'b1; a_x = 9'd1; a_y = 9'd1; a_colour = 4'h1;
    b_valid = 1'b1; b_x = 9'd2; b_y = 9'd2; b_colour = 4'h2;

    // Reset with traffic presented
    tick(); tick();
    check("rst_we", writeEn, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_col", colour, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    resetn = 1'b1;
    tick();
    check("rel_a_ready", a_ready, 1);
    check("rel_b_ready", b_ready, 1);
    check("rel_we", writeEn, 0);

    // Contention: three pixels into each source on the same edges
    got_q.delete(); got_k.delete(); exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      if (k < 3) begin
        a_valid = 1'b1; a_x = 9'(10 + k);  a_y = 9'(20 + k);  a_colour = 4'(1 + k);
        b_valid = 1'b1; b_x = 9'(100 + k); b_y = 9'(120 + k); b_colour = 4'(8 + k);
      end else begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
      tick();
      sample(k);
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{px: 9'(10 + k),  py: 9'(20 + k),  pc: 4'(1 + k)});
      exp_q.push_back('{px: 9'(100 + k), py: 9'(120 + k), pc: 4'(8 + k)});
    end
    check_seq("contend", 1);

    // Single pixels and clipping from the vector table
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_x = vecs[i].ax; a_y = vecs[i].ay; a_colour = vecs[i].ac;
      tick();
      a_valid = 1'b0;
      check($sformatf("vec%0d_we_pre", i), writeEn, 0);
      tick();
      check($sformatf("vec%0d_we", i), writeEn, vecs[i].ew);
      check($sformatf("vec%0d_x", i), x, vecs[i].ex);
      check($sformatf("vec%0d_y", i), y, vecs[i].ey);
      check($sformatf("vec%0d_col", i), colour, vecs[i].ec);
      check($sformatf("vec%0d_drop", i), drop_count, vecs[i].ed);
      tick();
      check($sformatf("vec%0d_we_post", i), writeEn, 0);
    end

    // Clear sweep with A buffering two pixels and B back-pressured
    a_valid = 1'b1; a_x = 9'd30; a_y = 9'd40; a_colour = 4'h3;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_start_busy", clear_busy, 1);
    check("clr_start_we", writeEn, 0);
    a_x = 9'd31; a_y = 9'd41; a_colour = 4'h4;
    b_sent = 0; bad = 0;
    for (int i = 0; i < 76800; i++) begin
      if (i == 1) a_valid = 1'b0;
      clear_req = (i == 1000);
      b_valid = 1'b1;
      b_x = 9'(50 + b_sent); b_y = 9'(60 + b_sent); b_colour = 4'(10 + b_sent);
      acc = b_ready;
      tick();
      if (acc) b_sent++;
      if (writeEn !== 1'b1 || x !== 9'(i % 320) || y !== 9'(i / 320) ||
          colour !== 4'h0 || clear_busy !== (i != 76799))
        bad++;
    end
    clear_req = 1'b0;
    check("sweep_bad_pixels", bad, 0);
    check("bp_b_accepts", b_sent, 4);
    check("bp_b_ready_full", b_ready, 0);
    check("sweep_end_busy", clear_busy, 0);
    b_valid = 1'b0;
    got_q.delete(); got_k.delete(); exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      tick();
      sample(k);
    end
    // Last grant before the sweep was A, so B leads
    exp_q.push_back('{px: 9'd50, py: 9'd60, pc: 4'd10});
    exp_q.push_back('{px: 9'd30, py: 9'd40, pc: 4'd3});
    exp_q.push_back('{px: 9'd51, py: 9'd61, pc: 4'd11});
    exp_q.push_back('{px: 9'd31, py: 9'd41, pc: 4'd4});
    exp_q.push_back('{px: 9'd52, py: 9'd62, pc: 4'd12});
    exp_q.push_back('{px: 9'd53, py: 9'd63, pc: 4'd13});
    check_seq("post_clear", 0);
    check("post_clear_drop", drop_count, 3);

    // Drop counter saturation
    sent = 0; we_seen = 1'b0;
    for (int cyc = 0; cyc < 1000 && sent < 300; cyc++) begin
      a_valid = 1'b1; a_x = 9'd400; a_y = 9'(cyc % 200); a_colour = 4'h5;
      acc = a_ready;
      tick();
      if (acc) sent++;
      if (writeEn) we_seen = 1'b1;
    end
    a_valid = 1'b0;
    repeat (4) begin
      tick();
      if (writeEn) we_seen = 1'b1;
    end
    check("sat_sent", sent, 300);
    check("sat_drop", drop_count, 255);
    check("sat_no_write", we_seen, 0);

    // Reset in the middle of a sweep
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (500) tick();
    check("mid_busy", clear_busy, 1);
    check("mid_we", writeEn, 1);
    check("mid_second_req_y", y, 1);
    resetn = 1'b0;
    #1;
    check("arst_busy", clear_busy, 0);
    check("arst_we", writeEn, 0);
    check("arst_x", x, 0);
    check("arst_y", y, 0);
    check("arst_col", colour, 0);
    check("arst_drop", drop_count, 0);
    check("arst_a_ready", a_ready, 0);
    check("arst_b_ready", b_ready, 0);
    tick();
    resetn = 1'b1;
    tick();
    check("rel2_busy", clear_busy, 0);
    check("rel2_a_ready", a_ready, 1);
    check("rel2_we", writeEn, 0);
    a_valid = 1'b1; a_x = 9'd7; a_y = 9'd8; a_colour = 4'h5;
    tick();
    a_valid = 1'b0;
    tick();
    check("rel2_pix_we", writeEn, 1);
    check("rel2_pix_x", x, 7);
    check("rel2_pix_y", y, 8);
    check("rel2_pix_col", colour, 5);
    tick();
    check("rel2_pix_we_off", writeEn, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
